tinker_mem_responder: RTL and testbench

TINKER_MEM_RESPONDER -- requirements
Module: tinker_mem_responder

---
 rtl/tinker_mem_responder.sv | 129 ++++++++++++
 tb/tb_tinker_mem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tinker_mem_responder.sv
// Single-outstanding byte-addressed memory responder with a fixed request-to-response latency.
// Little-endian 4/8-byte loads and stores; unaligned addresses allowed, out-of-range accesses flagged.
module tinker_mem_responder #(
    parameter int ADDR_W  = 19,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_size,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam int         DEPTH    = 1 << ADDR_W;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic        size_q;
    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] rdata_q;
    logic        err_q;

    logic [7:0]  mem [DEPTH];

    logic [32:0]       last_addr;
    logic              range_err;
    logic              do_access;
    logic              mem_we;
    logic [ADDR_W-1:0] base;
    logic [63:0]       load_data;

    // The extra top bit catches both ends past the store and wrap-around past 2^32.
    assign last_addr = {1'b0, addr_q} + (size_q ? 33'd7 : 33'd3);
    assign range_err = |last_addr[32:ADDR_W];
    assign do_access = (state_q == WAIT) && (cnt_q == 4'd0);
    assign mem_we    = do_access && write_q && !range_err && !reset;
    assign base      = addr_q[ADDR_W-1:0];

    // NOTE: always_comb gives every output a default first, so no path can infer a latch.
    always_comb begin
        load_data = '0;
        for (int i = 0; i < 8; i++) begin
            if ((i < 4) || size_q) begin
                load_data[8*i +: 8] = mem[base + ADDR_W'(i)];
            end
        end
        if (range_err || write_q) begin
            load_data = '0;
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            size_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        size_q  <= req_size;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= CNT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rdata_q <= load_data;
                        err_q   <= range_err;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the array has no reset: contents power up undefined and survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if ((i < 4) || size_q) begin
                    mem[base + ADDR_W'(i)] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_tinker_mem_responder.sv
// Scoreboard bench: drivers push expected responses, monitors pop and compare at each handshake.
// dut0 runs LATENCY=2 directed vectors; dut1 runs LATENCY=1 back-to-back traffic.
module tb_tinker_mem_responder;
    localparam int LAT0 = 2;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        w;
        logic        s;
        logic [31:0] a;
        logic [63:0] d;
        logic [63:0] rd;
        logic        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, req_write, req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [63:0] rsp_rdata;

    logic        req_valid1, req_ready1, req_write1, req_size1;
    logic [31:0] req_addr1;
    logic [63:0] req_wdata1;
    logic        rsp_valid1, rsp_ready1, rsp_err1, busy1;
    logic [63:0] rsp_rdata1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t got0, got1;

    tinker_mem_responder #(.ADDR_W(19), .LATENCY(LAT0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    tinker_mem_responder #(.ADDR_W(19), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
        .req_size(req_size1), .req_addr(req_addr1), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1),
        .rsp_err(rsp_err1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: compare whenever a response handshake is about to happen.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            check("dut0 rsp expected", 64'(sb0.size() != 0), 64'd1);
            if (sb0.size() != 0) begin
                got0 = sb0.pop_front();
                check("dut0 rdata", rsp_rdata, got0.rdata);
                check("dut0 err", 64'(rsp_err), 64'(got0.err));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && rsp_valid1) begin
            check("dut1 ready low in RESP", 64'(req_ready1), 64'd0);
            if (rsp_ready1) begin
                check("dut1 rsp expected", 64'(sb1.size() != 0), 64'd1);
                if (sb1.size() != 0) begin
                    got1 = sb1.pop_front();
                    check("dut1 rdata", rsp_rdata1, got1.rdata);
                    check("dut1 err", 64'(rsp_err1), 64'(got1.err));
                end
            end
        end
    end

    task automatic wait_ready();
        for (int k = 0; k < 50 && !req_ready; k++) begin
            @(posedge clk); #1;
        end
        check("dut0 req_ready wait", 64'(req_ready), 64'd1);
    endtask

    // Drives one request, returns #1 after the accepting edge with inputs scrambled.
    task automatic start_req(input logic w, input logic s, input logic [31:0] a, input logic [63:0] d);
        wait_ready();
        req_valid = 1'b1;
        req_write = w;
        req_size  = s;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = ~w;
        req_size  = ~s;
        req_addr  = ~a;
        req_wdata = ~d;
        check("dut0 accepted", 64'({busy, req_ready}), 64'b10);
    endtask

    task automatic wait_rsp(output int k);
        k = 0;
        while (!rsp_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic do_req(input logic w, input logic s, input logic [31:0] a, input logic [63:0] d,
                          input logic [63:0] rd, input logic e);
        int k;
        sb0.push_back('{rdata: rd, err: e});
        start_req(w, s, a, d);
        wait_rsp(k);
        check("dut0 latency", 64'(k), 64'(LAT0));
        @(posedge clk); #1;
        check("dut0 back to idle", 64'({rsp_valid, req_ready}), 64'b01);
    endtask

    vec_t vec1[5];
    int   acc[5];

    initial begin
        int   k;
        logic r;

        reset = 1'b1;
        req_valid = 0; req_write = 0; req_size = 0; req_addr = '0; req_wdata = '0; rsp_ready = 1;
        req_valid1 = 0; req_write1 = 0; req_size1 = 0; req_addr1 = '0; req_wdata1 = '0; rsp_ready1 = 1;
        #2;
        check("reset req_ready", 64'(req_ready), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset rsp_err", 64'(rsp_err), 64'd0);
        check("reset rsp_rdata", rsp_rdata, 64'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        do_req(1, 1, 32'h2000, 64'h1122334455667788, 64'h0, 0);
        do_req(0, 1, 32'h2000, 64'h0, 64'h1122334455667788, 0);
        do_req(0, 0, 32'h2003, 64'h0, 64'h0000000022334455, 0);
        do_req(1, 0, 32'h2000, 64'hFFFFFFFFA1B2C3D4, 64'h0, 0);
        do_req(0, 1, 32'h2000, 64'h0, 64'h11223344A1B2C3D4, 0);
        do_req(0, 1, 32'h0007FFF9, 64'h0, 64'h0, 1);
        do_req(1, 1, 32'h0007FFF8, 64'hDEADBEEF01234567, 64'h0, 0);
        do_req(0, 0, 32'h0007FFFC, 64'h0, 64'h00000000DEADBEEF, 0);
        do_req(0, 0, 32'h0007FFFD, 64'h0, 64'h0, 1);
        do_req(1, 1, 32'hFFFFFFFC, 64'h5555555555555555, 64'h0, 1);
        do_req(0, 1, 32'h0007FFF8, 64'h0, 64'hDEADBEEF01234567, 0);

        // Response held off for 5 cycles.
        sb0.push_back('{rdata: 64'h11223344A1B2C3D4, err: 1'b0});
        start_req(0, 1, 32'h2000, 64'h0);
        rsp_ready = 1'b0;
        wait_rsp(k);
        check("hold latency", 64'(k), 64'(LAT0));
        repeat (5) begin
            @(posedge clk); #1;
            check("hold state", 64'({rsp_valid, req_ready, busy, rsp_err}), 64'b1010);
            check("hold rdata", rsp_rdata, 64'h11223344A1B2C3D4);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("hold release", 64'({rsp_valid, busy}), 64'b00);

        // Reset during WAIT discards a pending store.
        do_req(1, 1, 32'h100, 64'h0123456789ABCDEF, 64'h0, 0);
        start_req(1, 1, 32'h100, 64'hAAAAAAAAAAAAAAAA);
        reset = 1'b1;
        #1;
        check("wait reset state", 64'({req_ready, busy, rsp_valid}), 64'b100);
        #1 reset = 1'b0;
        do_req(0, 1, 32'h100, 64'h0, 64'h0123456789ABCDEF, 0);

        // Reset during RESP drops the response.
        start_req(0, 1, 32'h100, 64'h0);
        rsp_ready = 1'b0;
        wait_rsp(k);
        check("resp before reset", 64'(rsp_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("resp reset flags", 64'({rsp_valid, rsp_err, busy, req_ready}), 64'b0001);
        check("resp reset rdata", rsp_rdata, 64'd0);
        #1 reset = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;

        // LATENCY=1 back-to-back with req_valid and rsp_ready held high.
        vec1[0] = '{1, 1, 32'h40, 64'h8877665544332211, 64'h0, 0};
        vec1[1] = '{1, 0, 32'h48, 64'hFFFFFFFFCAFEF00D, 64'h0, 0};
        vec1[2] = '{0, 1, 32'h40, 64'h0, 64'h8877665544332211, 0};
        vec1[3] = '{0, 0, 32'h44, 64'h0, 64'h0000000088776655, 0};
        vec1[4] = '{0, 0, 32'h47, 64'h0, 64'h00000000FEF00D88, 0};
        req_valid1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_write1 = vec1[i].w;
            req_size1  = vec1[i].s;
            req_addr1  = vec1[i].a;
            req_wdata1 = vec1[i].d;
            sb1.push_back('{rdata: vec1[i].rd, err: vec1[i].e});
            k = 0;
            do begin
                @(negedge clk);
                r = req_ready1;
                @(posedge clk); #1;
                k++;
            end while (!r && k < 20);
            check("dut1 accept", 64'(r), 64'd1);
            acc[i] = cyc;
        end
        req_valid1 = 1'b0;
        for (int i = 1; i < 5; i++) begin
            check("dut1 txn cycles", 64'(acc[i] - acc[i-1]), 64'd3);
        end

        repeat (6) @(posedge clk);
        #1;
        check("dut0 scoreboard drained", 64'(sb0.size()), 64'd0);
        check("dut1 scoreboard drained", 64'(sb1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
